// File: rtl/apb_harb_arb_pkg.sv
// apb_harb_arb_pkg: state encodings and master count shared by the arbiter files
package apb_harb_arb_pkg;

    localparam int NUM_MST = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10
    } arb_state_e;

endpackage

// File: rtl/apb_arb_pick.sv
// apb_arb_pick: combinational winner select, the master not equal to last_owner wins a tie
module apb_arb_pick
    import apb_harb_arb_pkg::*;
(
    input  logic [NUM_MST-1:0] req_i,
    input  logic               last_owner_i,
    output logic [NUM_MST-1:0] gnt_o
);

    // a lone requester wins outright; a tie goes to the master that did not own the bus last
    always_comb begin
        gnt_o = (&req_i) ? (last_owner_i ? 2'b01 : 2'b10) : req_i;
    end

endmodule

// File: rtl/apb_harb_arb.sv
// apb_harb_arb: two-master arbiter in front of the APB bridge (IDLE -> ADDR -> DATA)
// Build option APB_ARB_RR_EN: round-robin on conflict; undefined gives fixed priority to m0.
module apb_harb_arb
    import apb_harb_arb_pkg::*;
(
    input  logic        hclk,
    input  logic        hrst_b,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_write,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_done,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_write,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_done,
    output logic [31:0] arb_rdata,
    output logic        arb_err,
    output logic        harb_apb_hsel,
    output logic [31:0] harb_xx_haddr,
    output logic        harb_xx_hwrite,
    output logic [31:0] harb_xx_hwdata,
    input  logic        apb_harb_hready,
    input  logic [31:0] apb_harb_hrdata,
    input  logic [1:0]  apb_harb_hresp
);

    arb_state_e         state_q;
    logic               first_q;
    logic               last_owner_q;
    logic               hsel_q;
    logic [31:0]        haddr_q;
    logic               hwrite_q;
    logic [31:0]        hwdata_q;
    logic               m0_gnt_q;
    logic               m1_gnt_q;
    logic               m0_done_q;
    logic               m1_done_q;
    logic [31:0]        rdata_q;
    logic               err_q;
    logic               pick_owner;
    logic [NUM_MST-1:0] win_d;

    // pinning the tie-break owner to m1 makes the picker always favour m0
`ifdef APB_ARB_RR_EN
    assign pick_owner = last_owner_q;
`else
    assign pick_owner = 1'b1;
`endif

    apb_arb_pick u_pick (
        .req_i        ({m1_req, m0_req}),
        .last_owner_i (pick_owner),
        .gnt_o        (win_d)
    );

    // transfer sequencer; last_owner doubles as the owner of the outstanding transfer
    always_ff @(posedge hclk or negedge hrst_b) begin
        if (!hrst_b) begin
            state_q      <= IDLE;
            first_q      <= 1'b0;
            last_owner_q <= 1'b1;
            hsel_q       <= 1'b0;
            haddr_q      <= '0;
            hwrite_q     <= 1'b0;
            hwdata_q     <= '0;
            m0_gnt_q     <= 1'b0;
            m1_gnt_q     <= 1'b0;
            m0_done_q    <= 1'b0;
            m1_done_q    <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            m0_gnt_q  <= 1'b0;
            m1_gnt_q  <= 1'b0;
            m0_done_q <= 1'b0;
            m1_done_q <= 1'b0;
            hsel_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|win_d) begin
                        {m1_gnt_q, m0_gnt_q} <= win_d;
                        last_owner_q <= win_d[1];
                        haddr_q      <= win_d[1] ? m1_addr  : m0_addr;
                        hwrite_q     <= win_d[1] ? m1_write : m0_write;
                        hwdata_q     <= win_d[1] ? m1_wdata : m0_wdata;
                        hsel_q       <= 1'b1;
                        state_q      <= ADDR;
                    end
                end
                ADDR: begin
                    first_q <= 1'b1;
                    state_q <= DATA;
                end
                DATA: begin
                    first_q <= 1'b0;
                    if (!first_q && apb_harb_hready) begin
                        if (!hwrite_q) rdata_q <= apb_harb_hrdata;
                        err_q     <= |apb_harb_hresp;
                        m0_done_q <= ~last_owner_q;
                        m1_done_q <= last_owner_q;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m0_gnt         = m0_gnt_q;
    assign m1_gnt         = m1_gnt_q;
    assign m0_done        = m0_done_q;
    assign m1_done        = m1_done_q;
    assign arb_rdata      = rdata_q;
    assign arb_err        = err_q;
    assign harb_apb_hsel  = hsel_q;
    assign harb_xx_haddr  = haddr_q;
    assign harb_xx_hwrite = hwrite_q;
    assign harb_xx_hwdata = hwdata_q;

endmodule
